ucsbece154_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single burst-read SDRAM model between the instruction cache (port 0) and the data cache read-miss path (port 1). It accepts one block-fill request at a time, issues it to memory as a one-cycle `ReadRequest` pulse, and routes the `BLOCK_WORDS` returned beats to the granted port. It releases the memory only after the final beat, so two bursts never overlap. The block sits between both caches' miss handlers and `ucsbece154_imem`.

---
 rtl/ucsbece154_mem_pkg.sv | 15 +
 rtl/ucsbece154_arb_pick.sv | 41 ++++
 rtl/ucsbece154_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ucsbece154_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154_mem_pkg.sv
// Shared definitions for the burst-read memory subsystem: arbiter state
// encoding, number of memory requesters and the default block size that
// the caches, the memory model and the arbiter must agree on.
package ucsbece154_mem_pkg;

  localparam int NUM_MEM_PORTS = 2;
  localparam int BLOCK_WORDS   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BURST = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ucsbece154_arb_pick.sv
// Combinational two-requester selector returning a one-hot winner.
// Build option: define UCSBECE154_ARB_RR_EN to break ties in favour of the
// port that was not served last; otherwise port 0 always wins a tie.
module ucsbece154_arb_pick
  import ucsbece154_mem_pkg::*;
(
  input  logic                     req0_i,
  input  logic                     req1_i,
  input  logic                     last_gnt_i,
  output logic [NUM_MEM_PORTS-1:0] win_o
);

`ifndef UCSBECE154_ARB_RR_EN
  // Fixed priority ignores the history bit; keep it visibly consumed.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
`endif

  // Select at most one requester per evaluation.
  always_comb begin
    // NOTE: assigning a default before any branch keeps every path driven,
    // so no latch is inferred when no request is pending.
    win_o = '0;
`ifdef UCSBECE154_ARB_RR_EN
    if (req0_i && req1_i) begin
      win_o = last_gnt_i ? 2'b01 : 2'b10;
    end else if (req0_i) begin
      win_o = 2'b01;
    end else if (req1_i) begin
      win_o = 2'b10;
    end
`else
    if (req0_i) begin
      win_o = 2'b01;
    end else if (req1_i) begin
      win_o = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// Two-port block-fill arbiter in front of the burst-read memory. Port 0 is
// the instruction cache, port 1 the data-cache read-miss path. One burst is
// in flight at a time; beats are routed combinationally to the granted port.
// Build option: UCSBECE154_ARB_RR_EN enables round-robin tie breaking.
module ucsbece154_mem_arbiter
  import ucsbece154_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = ucsbece154_mem_pkg::BLOCK_WORDS,
  parameter int ADDR_W      = 32
) (
  input  logic                           clk,
  input  logic                           reset,

  input  logic                           Req0,
  input  logic [ADDR_W-1:0]              Addr0,
  output logic                           Gnt0,
  output logic                           Ready0,
  output logic [31:0]                    Data0,
  output logic                           Done0,

  input  logic                           Req1,
  input  logic [ADDR_W-1:0]              Addr1,
  output logic                           Gnt1,
  output logic                           Ready1,
  output logic [31:0]                    Data1,
  output logic                           Done1,

  output logic [$clog2(BLOCK_WORDS)-1:0] WordIdx,

  output logic                           MemReadRequest,
  output logic [ADDR_W-1:0]              MemReadAddress,
  input  logic [31:0]                    MemDataIn,
  input  logic                           MemDataReady
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  // One spare bit so the counter can never wrap inside a burst.
  localparam int CNT_W = IDX_W + 1;
  // Word index bits plus the two byte-offset bits of a 32-bit word.
  localparam int OFF_W = IDX_W + 2;
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  arb_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_MEM_PORTS-1:0] gnt_q, gnt_d;
  logic                     req_q, req_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;

  logic [NUM_MEM_PORTS-1:0] win;
  logic [ADDR_W-1:0]        sel_addr;
  logic                     last_gnt;
  logic                     beat;
  logic                     last_beat;

`ifdef UCSBECE154_ARB_RR_EN
  // 1 means port 1 was served last, so port 0 wins the next tie.
  logic last_gnt_q, last_gnt_d;
  assign last_gnt = last_gnt_q;
`else
  assign last_gnt = 1'b1;
`endif

  ucsbece154_arb_pick u_pick (
    .req0_i     (Req0),
    .req1_i     (Req1),
    .last_gnt_i (last_gnt),
    .win_o      (win)
  );

  assign sel_addr  = win[1] ? Addr1 : Addr0;
  // Beats only count while a burst is actually outstanding; anything the
  // memory presents in IDLE or ISSUE is dropped.
  assign beat      = MemDataReady && (state_q == BURST);
  assign last_beat = beat && (cnt_q == LAST_BEAT);

  // Next-state logic: grant in IDLE, one request cycle in ISSUE, count beats in BURST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
`ifdef UCSBECE154_ARB_RR_EN
    last_gnt_d = last_gnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win != '0) begin
          gnt_d   = win;
          req_d   = 1'b1;
          addr_d  = sel_addr & ALIGN_MASK;
          cnt_d   = '0;
          state_d = ISSUE;
`ifdef UCSBECE154_ARB_RR_EN
          last_gnt_d = win[1];
`endif
        end
      end
      ISSUE: begin
        state_d = BURST;
      end
      BURST: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            // Release memory and return every output to its idle value.
            cnt_d   = '0;
            gnt_d   = '0;
            addr_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
        addr_d  = '0;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
`ifdef UCSBECE154_ARB_RR_EN
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
`ifdef UCSBECE154_ARB_RR_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  assign Gnt0           = gnt_q[0];
  assign Gnt1           = gnt_q[1];
  assign Ready0         = beat & gnt_q[0];
  assign Ready1         = beat & gnt_q[1];
  assign Done0          = last_beat & gnt_q[0];
  assign Done1          = last_beat & gnt_q[1];
  assign Data0          = MemDataIn;
  assign Data1          = MemDataIn;
  assign WordIdx        = cnt_q[IDX_W-1:0];
  assign MemReadRequest = req_q;
  assign MemReadAddress = addr_q;

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Directed bench for the two-port memory arbiter. The bench plays the memory:
// it waits for the request pulse, leaves one idle cycle, then returns four
// beats and checks routing, word index and completion on every beat.
module tb_ucsbece154_mem_arbiter;

`ifdef UCSBECE154_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Req0, Req1;
  logic [31:0] Addr0, Addr1;
  logic        Gnt0, Gnt1, Ready0, Ready1, Done0, Done1;
  logic [31:0] Data0, Data1;
  logic [1:0]  WordIdx;
  logic        MemReadRequest;
  logic [31:0] MemReadAddress;
  logic [31:0] MemDataIn;
  logic        MemDataReady;

  int checks = 0;
  int errors = 0;

  ucsbece154_mem_arbiter #(.BLOCK_WORDS(4), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .Req0           (Req0),
    .Addr0          (Addr0),
    .Gnt0           (Gnt0),
    .Ready0         (Ready0),
    .Data0          (Data0),
    .Done0          (Done0),
    .Req1           (Req1),
    .Addr1          (Addr1),
    .Gnt1           (Gnt1),
    .Ready1         (Ready1),
    .Data1          (Data1),
    .Done1          (Done1),
    .WordIdx        (WordIdx),
    .MemReadRequest (MemReadRequest),
    .MemReadAddress (MemReadAddress),
    .MemDataIn      (MemDataIn),
    .MemDataReady   (MemDataReady)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    Req0 = 1'b0; Req1 = 1'b0; Addr0 = '0; Addr1 = '0;
    MemDataIn = '0; MemDataReady = 1'b0;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Serve one burst for the expected port; optionally drop that port's
  // request after beat number drop_beat.
  task automatic do_burst(input int port, input logic [31:0] exp_addr,
                          input logic [31:0] base, input int drop_beat);
    int budget;
    logic [1:0] exp_gnt;
    logic [1:0] rdy;
    logic [1:0] dn;
    logic [31:0] dat;
    budget = 0;
    exp_gnt = (port == 1) ? 2'b10 : 2'b01;
    while (!MemReadRequest && budget < 20) begin
      tick;
      budget++;
    end
    checks++;
    if (MemReadRequest !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout port%0d: got %b required 1", port, MemReadRequest);
      return;
    end
    checks++;
    if (MemReadAddress !== exp_addr) begin
      errors++;
      $display("FAIL req_addr port%0d: got %h required %h", port, MemReadAddress, exp_addr);
    end
    checks++;
    if ({Gnt1, Gnt0} !== exp_gnt) begin
      errors++;
      $display("FAIL grant port%0d: got %b required %b", port, {Gnt1, Gnt0}, exp_gnt);
    end
    tick;
    checks++;
    if (MemReadRequest !== 1'b0) begin
      errors++;
      $display("FAIL req_pulse port%0d: got %b required 0", port, MemReadRequest);
    end
    tick;
    for (int i = 0; i < 4; i++) begin
      MemDataReady = 1'b1;
      MemDataIn    = base + 32'(i);
      #1;
      rdy = (port == 1) ? {Ready1, Ready0} : {Ready0, Ready1};
      dn  = (port == 1) ? {Done1, Done0}   : {Done0, Done1};
      dat = (port == 1) ? Data1 : Data0;
      checks++;
      if (rdy !== 2'b10) begin
        errors++;
        $display("FAIL ready port%0d beat%0d: got own/other %b required 10", port, i, rdy);
      end
      checks++;
      if (dat !== base + 32'(i)) begin
        errors++;
        $display("FAIL data port%0d beat%0d: got %h required %h", port, i, dat, base + 32'(i));
      end
      checks++;
      if (WordIdx !== 2'(i)) begin
        errors++;
        $display("FAIL word_idx port%0d beat%0d: got %0d required %0d", port, i, WordIdx, i);
      end
      checks++;
      if (dn !== {(i == 3), 1'b0}) begin
        errors++;
        $display("FAIL done port%0d beat%0d: got own/other %b required %b", port, i, dn, {(i == 3), 1'b0});
      end
      tick;
      if (i == drop_beat) begin
        if (port == 1) Req1 = 1'b0;
        else           Req0 = 1'b0;
      end
    end
    MemDataReady = 1'b0;
    MemDataIn    = '0;
    checks++;
    if ({Gnt1, Gnt0} !== 2'b00) begin
      errors++;
      $display("FAIL release port%0d: got %b required 00", port, {Gnt1, Gnt0});
    end
  endtask

  task automatic test_reset;
    apply_reset;
    checks++;
    if ({Gnt0, Gnt1, Ready0, Ready1, Done0, Done1, MemReadRequest, WordIdx} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0",
               {Gnt0, Gnt1, Ready0, Ready1, Done0, Done1, MemReadRequest, WordIdx});
    end
    checks++;
    if (MemReadAddress !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h required 0", MemReadAddress);
    end
  endtask

  task automatic test_single_fill;
    apply_reset;
    Req0 = 1'b1; Addr0 = 32'h24;
    do_burst(0, 32'h20, 32'hA000_0000, -1);
    Req0 = 1'b0;
    tick;
    checks++;
    if ({Gnt1, Gnt0, MemReadRequest} !== 3'b000) begin
      errors++;
      $display("FAIL single_idle: got %b required 000", {Gnt1, Gnt0, MemReadRequest});
    end
  endtask

  task automatic test_simultaneous;
    apply_reset;
    Req0 = 1'b1; Req1 = 1'b1; Addr0 = 32'h100; Addr1 = 32'h23C;
    do_burst(0, 32'h100, 32'hB000_0000, -1);
    Req0 = 1'b0;
    // One edge after the final beat: back in IDLE, nothing issued yet.
    checks++;
    if (MemReadRequest !== 1'b0) begin
      errors++;
      $display("FAIL sim_gap: got %b required 0", MemReadRequest);
    end
    tick;
    checks++;
    if ({MemReadRequest, Gnt1, Gnt0} !== 3'b110) begin
      errors++;
      $display("FAIL sim_second_req: got %b required 110", {MemReadRequest, Gnt1, Gnt0});
    end
    do_burst(1, 32'h230, 32'hB100_0000, -1);
    Req1 = 1'b0;
  endtask

  task automatic test_round_robin;
    int exp_port;
    apply_reset;
    Req0 = 1'b1; Req1 = 1'b1; Addr0 = 32'h300; Addr1 = 32'h404;
    for (int b = 0; b < 4; b++) begin
      exp_port = RR ? (b % 2) : 0;
      do_burst(exp_port, (exp_port == 1) ? 32'h400 : 32'h300,
               32'hC000_0000 + 32'(b * 16), -1);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tick;
  endtask

  task automatic test_drop_mid_burst;
    apply_reset;
    Req1 = 1'b1; Addr1 = 32'h44;
    do_burst(1, 32'h40, 32'hD000_0000, 1);
    Req0 = 1'b1; Addr0 = 32'h88;
    do_burst(0, 32'h80, 32'hD100_0000, -1);
    Req0 = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_burst;
    apply_reset;
    Req0 = 1'b1; Addr0 = 32'h1FC;
    tick;
    tick;
    for (int i = 0; i < 2; i++) begin
      MemDataReady = 1'b1;
      MemDataIn    = 32'h5000 + 32'(i);
      #1;
      checks++;
      if ({Ready0, WordIdx} !== {1'b1, 2'(i)}) begin
        errors++;
        $display("FAIL rst_pre_beat%0d: got %b required %b", i, {Ready0, WordIdx}, {1'b1, 2'(i)});
      end
      tick;
    end
    MemDataReady = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({Gnt0, Gnt1, Ready0, Ready1, Done0, Done1, MemReadRequest, WordIdx} !== 9'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b required 0",
               {Gnt0, Gnt1, Ready0, Ready1, Done0, Done1, MemReadRequest, WordIdx});
    end
    checks++;
    if (MemReadAddress !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_addr: got %h required 0", MemReadAddress);
    end
    do_burst(0, 32'h1F0, 32'h6000_0000, -1);
    Req0 = 1'b0;
    tick;
  endtask

  task automatic test_spurious_ready;
    apply_reset;
    MemDataReady = 1'b1;
    MemDataIn    = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({Gnt0, Gnt1, Ready0, Ready1, Done0, Done1, MemReadRequest, WordIdx} !== 9'b0) begin
        errors++;
        $display("FAIL spurious_cycle%0d: got %b required 0", i,
                 {Gnt0, Gnt1, Ready0, Ready1, Done0, Done1, MemReadRequest, WordIdx});
      end
      tick;
    end
    MemDataReady = 1'b0;
    Req0 = 1'b1; Addr0 = 32'h0;
    do_burst(0, 32'h0, 32'h7000_0000, -1);
    Req0 = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_fill;
    test_simultaneous;
    test_round_robin;
    test_drop_mid_burst;
    test_reset_mid_burst;
    test_spurious_ready;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
